// File: rtl/bcd_to_bin_seq_if.sv
// Handshake bundle for the sequential BCD-to-binary converter.
// Optional macro BCD_SIGN_EN adds sign_in and widens bin_out by one bit.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
);
`ifdef BCD_SIGN_EN
  localparam int BIN_W = OUT_W + 1;
  logic sign_in;
`else
  localparam int BIN_W = OUT_W;
`endif

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

`ifdef BCD_SIGN_EN
  modport master (output start, bcd_in, sign_in, input busy, done, bin_out, err);
  modport slave  (input start, bcd_in, sign_in, output busy, done, bin_out, err);
`else
  modport master (output start, bcd_in, input busy, done, bin_out, err);
  modport slave  (input start, bcd_in, output busy, done, bin_out, err);
`endif
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first (acc*10 + d).
// Optional macro BCD_SIGN_EN: signed result, negated on load when sign_in was set.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_to_bin_seq_if.slave bus
);
`ifdef BCD_SIGN_EN
  localparam int BIN_W = OUT_W + 1;
`else
  localparam int BIN_W = OUT_W;
`endif
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state;
  logic [4*DIGITS-1:0] shift;
  logic [OUT_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic                err_flag;
  logic                sign;
  logic                busy_r;
  logic                done_r;
  logic                err_r;
  logic [BIN_W-1:0]    bin_r;

  logic [3:0]          digit;
  logic                digit_bad;
  logic [3:0]          digit_ok;
  logic [OUT_W+3:0]    acc_wide;
  logic [OUT_W-1:0]    acc_next;
  logic [3:0]          unused_hi;
  logic [BIN_W-1:0]    result;

  function automatic logic signed [BIN_W-1:0] apply_sign(
    input logic [OUT_W-1:0] mag,
    input logic             neg
  );
    logic signed [BIN_W-1:0] m;
    m = signed'(BIN_W'(mag));
    return neg ? -m : m;
  endfunction

  assign digit     = shift[4*DIGITS-1 -: 4];
  assign digit_bad = (digit > 4'd9);
  assign digit_ok  = digit_bad ? 4'd0 : digit;

  // Full-width acc*10 + d; with a legal OUT_W the top four bits are always zero.
  assign acc_wide  = {1'b0, acc, 3'b000} + {2'b00, acc, 1'b0} + {{OUT_W{1'b0}}, digit_ok};
  assign acc_next  = acc_wide[OUT_W-1:0];
  assign unused_hi = acc_wide[OUT_W+3:OUT_W];

`ifdef BCD_SIGN_EN
  assign result = $unsigned(apply_sign(acc_next, sign));
`else
  assign result = $unsigned(apply_sign(acc_next, 1'b0));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      acc      <= '0;
      cnt      <= '0;
      err_flag <= 1'b0;
      sign     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      bin_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            shift    <= bus.bcd_in;
            acc      <= '0;
            err_flag <= 1'b0;
            cnt      <= '0;
`ifdef BCD_SIGN_EN
            sign     <= bus.sign_in;
`else
            sign     <= 1'b0;
`endif
            busy_r   <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          acc      <= acc_next;
          err_flag <= err_flag | digit_bad;
          shift    <= shift << 4;
          cnt      <= cnt + 1'b1;
          // Last digit: results are loaded from the combinational next values.
          if (cnt == LAST) begin
            bin_r  <= result;
            err_r  <= err_flag | digit_bad;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.bin_out = bin_r;
  assign bus.err     = err_r;
endmodule
